// File: rtl/stream_mux_arb.sv
// stream_mux_arb: registered N:1 stream mux with fixed-select or round-robin arbitration
// feeding a one-entry output register with its own valid/ready handshake.
module stream_mux_arb #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] a_in,
  input  logic [NUM_CH-1:0]        valid_in,
  output logic [NUM_CH-1:0]        ready_out,
  input  logic                     mode_in,
  input  logic [SEL_W-1:0]         sel_in,
  output logic [DATA_W-1:0]        y_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [SEL_W-1:0]         grant_out,
  output logic [CNT_W-1:0]         xfer_cnt_out
);
  logic [SEL_W-1:0]  rr_q, rr_d, grant_q, grant_d, cand;
  logic [DATA_W-1:0] y_q, y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              v_q, v_d, has_cand, load_en, xfer;
  logic [SEL_W:0]    probe;
  // Scan from the farthest offset down so the nearest valid channel after rr_q wins.
  always_comb begin
    cand = '0;
    has_cand = 1'b0;
    probe = '0;
    if (mode_in) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        probe = {1'b0, rr_q} + (SEL_W+1)'(k);
        probe = probe >= (SEL_W+1)'(NUM_CH) ? probe - (SEL_W+1)'(NUM_CH) : probe;
        if (valid_in[probe[SEL_W-1:0]]) begin
          cand = probe[SEL_W-1:0];
          has_cand = 1'b1;
        end
      end
    end else begin
      cand = sel_in;
      has_cand = int'(sel_in) < NUM_CH;
    end
  end
  assign load_en   = !v_q || ready_in;
  assign xfer      = load_en && has_cand && valid_in[cand];
  assign ready_out = (xfer && !reset) ? (NUM_CH)'(1) << cand : '0;
  always_comb begin
    y_d     = xfer ? a_in[cand*DATA_W +: DATA_W] : y_q;
    grant_d = xfer ? cand : grant_q;
    v_d     = load_en ? xfer : v_q;
    cnt_d   = cnt_q + CNT_W'(xfer);
    rr_d    = (xfer && mode_in) ? (int'(cand) == NUM_CH - 1 ? '0 : cand + 1'b1) : rr_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      y_q     <= '0;
      v_q     <= 1'b0;
      grant_q <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      y_q     <= y_d;
      v_q     <= v_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end
  assign y_out        = y_q;
  assign valid_out    = v_q;
  assign grant_out    = grant_q;
  assign xfer_cnt_out = cnt_q;
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: vector table for handshake/arbitration sequences, scoreboard-checked
// fixed-mode sweep, a 3-channel instance for the out-of-range select, and async reset.
module tb_stream_mux_arb;
  logic        clock = 1'b0, reset = 1'b1;
  logic [31:0] a_in = '0;
  logic [3:0]  valid_in = '0, ready_out;
  logic        mode_in = 1'b0, ready_in = 1'b0, valid_out;
  logic [1:0]  sel_in = '0, grant_out;
  logic [7:0]  y_out;
  logic [15:0] xfer_cnt_out;
  logic [23:0] a3 = '0;
  logic [2:0]  v3 = '0, r3;
  logic [1:0]  s3 = '0, g3;
  logic        rin3 = 1'b1, vo3;
  logic [7:0]  y3;
  logic [15:0] c3;
  int tests = 0, fails = 0;
  always #5 clock = ~clock;
  stream_mux_arb dut (.clock(clock), .reset(reset), .a_in(a_in), .valid_in(valid_in),
    .ready_out(ready_out), .mode_in(mode_in), .sel_in(sel_in), .y_out(y_out),
    .valid_out(valid_out), .ready_in(ready_in), .grant_out(grant_out), .xfer_cnt_out(xfer_cnt_out));
  stream_mux_arb #(.NUM_CH(3), .DATA_W(8), .SEL_W(2), .CNT_W(16)) dut3 (.clock(clock),
    .reset(reset), .a_in(a3), .valid_in(v3), .ready_out(r3), .mode_in(1'b0), .sel_in(s3),
    .y_out(y3), .valid_out(vo3), .ready_in(rin3), .grant_out(g3), .xfer_cnt_out(c3));
  typedef struct {
    logic mode; logic [1:0] sel; logic [3:0] vin; logic rin; logic [31:0] a;
    logic [3:0] e_rdy; logic [7:0] e_y; logic [1:0] e_g; logic e_v; logic [15:0] e_cnt;
  } vec_t;
  typedef struct { logic [7:0] y; logic [1:0] g; logic [15:0] cnt; } exp_t;
  vec_t vecs[18];
  exp_t sb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic apply(input vec_t v, input string tag);
    mode_in = v.mode; sel_in = v.sel; valid_in = v.vin; ready_in = v.rin; a_in = v.a;
    #1 chk({tag, " ready_out"}, 32'(ready_out), 32'(v.e_rdy));
    @(posedge clock); #1;
    chk({tag, " y_out"}, 32'(y_out), 32'(v.e_y));
    chk({tag, " grant_out"}, 32'(grant_out), 32'(v.e_g));
    chk({tag, " valid_out"}, 32'(valid_out), 32'(v.e_v));
    chk({tag, " xfer_cnt"}, 32'(xfer_cnt_out), 32'(v.e_cnt));
    @(negedge clock);
  endtask
  initial begin
    logic [15:0] cnt;
    exp_t e;
    //               mode sel vin     rin a             e_rdy    e_y    g  v  cnt
    vecs[0]  = '{1'b0, 2, 4'b0100, 1, 32'h44332211, 4'b0100, 8'h33, 2, 1, 1};
    vecs[1]  = '{1'b1, 0, 4'b1111, 1, 32'h44332211, 4'b0001, 8'h11, 0, 1, 2};
    vecs[2]  = '{1'b1, 0, 4'b1111, 1, 32'h44332211, 4'b0010, 8'h22, 1, 1, 3};
    vecs[3]  = '{1'b1, 0, 4'b1111, 1, 32'h44332211, 4'b0100, 8'h33, 2, 1, 4};
    vecs[4]  = '{1'b1, 0, 4'b1111, 1, 32'h44332211, 4'b1000, 8'h44, 3, 1, 5};
    vecs[5]  = '{1'b1, 0, 4'b1111, 1, 32'h44332211, 4'b0001, 8'h11, 0, 1, 6};
    vecs[6]  = '{1'b1, 0, 4'b1111, 1, 32'h44332211, 4'b0010, 8'h22, 1, 1, 7};
    vecs[7]  = '{1'b1, 0, 4'b1010, 1, 32'h44332211, 4'b1000, 8'h44, 3, 1, 8};
    vecs[8]  = '{1'b1, 0, 4'b1010, 1, 32'h44332211, 4'b0010, 8'h22, 1, 1, 9};
    vecs[9]  = '{1'b1, 0, 4'b1010, 1, 32'h44332211, 4'b1000, 8'h44, 3, 1, 10};
    vecs[10] = '{1'b1, 0, 4'b1010, 1, 32'h44332211, 4'b0010, 8'h22, 1, 1, 11};
    vecs[11] = '{1'b1, 0, 4'b0000, 1, 32'h44332211, 4'b0000, 8'h22, 1, 0, 11};
    vecs[12] = '{1'b0, 0, 4'b0001, 1, 32'h44332211, 4'b0001, 8'h11, 0, 1, 12};
    vecs[13] = '{1'b1, 0, 4'b1111, 0, 32'h44332211, 4'b0000, 8'h11, 0, 1, 12};
    vecs[14] = '{1'b1, 0, 4'b1111, 0, 32'h44332211, 4'b0000, 8'h11, 0, 1, 12};
    vecs[15] = '{1'b1, 0, 4'b1111, 0, 32'h44332211, 4'b0000, 8'h11, 0, 1, 12};
    vecs[16] = '{1'b1, 0, 4'b1111, 1, 32'h44332211, 4'b0100, 8'h33, 2, 1, 13};
    vecs[17] = '{1'b0, 3, 4'b1000, 1, 32'h44332211, 4'b1000, 8'h44, 3, 1, 14};
    valid_in = 4'b1111;
    #3;
    chk("reset ready_out", 32'(ready_out), 0);
    chk("reset y_out", 32'(y_out), 0);
    chk("reset valid_out", 32'(valid_out), 0);
    chk("reset grant_out", 32'(grant_out), 0);
    chk("reset xfer_cnt", 32'(xfer_cnt_out), 0);
    @(negedge clock) reset = 1'b0;
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));
    // Fixed-mode sweep: expected word pushed on drive, popped after the loading edge.
    cnt = 16'd14;
    mode_in = 1'b0; valid_in = 4'b1111; ready_in = 1'b1;
    for (int s = 0; s < 4; s++)
      for (int v = 0; v < 16; v++) begin
        sel_in = 2'(s);
        for (int ch = 0; ch < 4; ch++) a_in[ch*8 +: 8] = 8'((v << 4) | ((v + ch * 5) & 15));
        cnt++;
        sb.push_back('{8'((v << 4) | ((v + s * 5) & 15)), 2'(s), cnt});
        #1 chk("sweep ready_out", 32'(ready_out), 32'(4'b0001 << s));
        @(posedge clock); #1;
        e = sb.pop_front();
        chk("sweep y_out", 32'(y_out), 32'(e.y));
        chk("sweep grant_out", 32'(grant_out), 32'(e.g));
        chk("sweep xfer_cnt", 32'(xfer_cnt_out), 32'(e.cnt));
        @(negedge clock);
      end
    chk("sweep queue drained", 32'(sb.size()), 0);
    // Three-channel instance: select 3 has no channel behind it.
    v3 = 3'b111; a3 = 24'hCCBBAA; s3 = 2'd3;
    for (int i = 0; i < 4; i++) begin
      #1 chk("nch3 sel3 ready", 32'(r3), 0);
      @(posedge clock); #1;
      chk("nch3 sel3 valid", 32'(vo3), 0);
      chk("nch3 sel3 cnt", 32'(c3), 0);
      @(negedge clock);
    end
    s3 = 2'd2;
    #1 chk("nch3 sel2 ready", 32'(r3), 32'(3'b100));
    @(posedge clock); #1;
    chk("nch3 sel2 y", 32'(y3), 32'hCC);
    chk("nch3 sel2 cnt", 32'(c3), 1);
    @(negedge clock);
    // Async reset between edges with a full output register.
    mode_in = 1'b1; valid_in = 4'b1111; ready_in = 1'b0; a_in = 32'h44332211;
    #2 chk("pre-reset valid_out", 32'(valid_out), 1);
    reset = 1'b1;
    #1;
    chk("async valid_out", 32'(valid_out), 0);
    chk("async y_out", 32'(y_out), 0);
    chk("async grant_out", 32'(grant_out), 0);
    chk("async xfer_cnt", 32'(xfer_cnt_out), 0);
    chk("async ready_out", 32'(ready_out), 0);
    @(negedge clock) reset = 1'b0;
    apply('{1'b1, 0, 4'b1111, 1, 32'h44332211, 4'b0001, 8'h11, 0, 1, 1}, "post-reset rr0");
    apply('{1'b1, 0, 4'b1111, 1, 32'h44332211, 4'b0010, 8'h22, 1, 1, 2}, "post-reset rr1");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised, registered N:1 stream multiplexer. Successor to the combinational 4:1 mux.
- Each of NUM_CH input channels carries DATA_W-bit data with a valid/ready handshake.
- Channel selection mode:
  - Fixed: the channel is chosen by sel_in.
  - Round-robin: the block arbitrates among channels that present valid data.
- The winner is captured into a one-entry output register with its own valid/ready handshake, so the block sits between producer streams and a single consumer.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 8, data width per channel.
- SEL_W, 2, select/grant width. Must equal ceil(log2(NUM_CH)).
- CNT_W, 16, width of the transfer counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- a_in  input  NUM_CH*DATA_W  channel data. Channel i occupies bits [i*DATA_W +: DATA_W].
- valid_in  input  NUM_CH  per-channel data valid.
- ready_out  output  NUM_CH  per-channel accept, combinational. At most one bit is high.
- mode_in  input  1  0 = fixed select, 1 = round-robin.
- sel_in  input  SEL_W  channel select, used in fixed mode only.
- y_out  output  DATA_W  registered output data.
- valid_out  output  1  output register holds data.
- ready_in  input  1  consumer accepts y_out.
- grant_out  output  SEL_W  channel index of the data currently in y_out.
- xfer_cnt_out  output  CNT_W  count of accepted input transfers.

Behaviour:
- Reset (async assert, sync release):
  - y_out = 0, valid_out = 0, grant_out = 0, xfer_cnt_out = 0.
  - Round-robin pointer rr_ptr = 0.
  - ready_out = 0 while reset is high.
- load_en = !valid_out || ready_in. The register can accept new data when it is empty or being drained in the same cycle.
- Fixed mode (mode_in = 0):
  - Candidate channel c = sel_in.
  - If sel_in >= NUM_CH, there is no candidate.
- Round-robin mode (mode_in = 1):
  - c = first index with valid_in set, searching rr_ptr, rr_ptr+1, ... with wrap mod NUM_CH.
  - No candidate if valid_in == 0.
- Transfer condition: load_en && candidate exists && valid_in[c]. When it holds:
  - ready_out[c] = 1 combinationally.
  - On the clock edge: y_out <= channel c data, grant_out <= c, valid_out <= 1, xfer_cnt_out <= xfer_cnt_out + 1.
- The transfer counter wraps from 2^CNT_W-1 to 0.
- rr_ptr update:
  - Updated only on a transfer in round-robin mode: rr_ptr <= (c+1) mod NUM_CH. Wrap from NUM_CH-1 to 0.
  - Retained in fixed mode and on mode switches.
- load_en with no transfer: valid_out <= 0. y_out and grant_out hold their previous values.
- !load_en (valid_out = 1, ready_in = 0): all ready_out = 0. y_out, grant_out and valid_out hold; no data is lost.
- Latency: input accept to valid_out is 1 cycle.
- Throughput: one transfer per cycle when ready_in is held high (drain and load in the same cycle).
- Non-selected channels always see ready_out = 0. Their valid_in may stay asserted and they must hold data, per the handshake rule: the producer holds data while valid is high and ready is low.
- mode_in and sel_in are sampled combinationally each cycle. A change takes effect on the next transfer decision.
- Reset mid-stream: data in the output register is discarded. valid_out = 0 immediately (async).

Test Plan:
- Reset then fixed mode:
  - Stimulus: sel_in = 2, a_in = 0x44_33_22_11, valid_in = 4'b0100, ready_in = 1.
  - Required: ready_out = 4'b0100. Next cycle y_out = 0x33, grant_out = 2, valid_out = 1, xfer_cnt_out = 1.
- Fixed-mode sweep:
  - Stimulus: all channels valid, all 16 values on each channel × sel_in 0..3, 10 ns steps.
  - Required: y_out always equals channel sel_in data one cycle later.
- Round-robin fairness:
  - Stimulus: mode_in = 1, valid_in = 4'b1111 held, ready_in = 1.
  - Required: grant_out sequence 0,1,2,3,0,1; xfer_cnt_out increments every cycle.
  - Stimulus: valid_in = 4'b1010.
  - Required: grants alternate 1,3,1,3.
- Backpressure:
  - Stimulus: register full with 0x11, ready_in = 0 for 3 cycles, valid_in = 4'b1111.
  - Required: ready_out = 0, y_out stays 0x11 and valid_out stays 1, xfer_cnt_out frozen. After ready_in = 1, the next channel in rr order loads in the same cycle.
- Empty/drain:
  - Stimulus: valid_in = 0, ready_in = 1.
  - Required: valid_out falls to 0 after one cycle; y_out keeps its last value.
  - Stimulus: with NUM_CH = 3, sel_in = 3.
  - Required: no transfer ever occurs.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges while valid_out = 1.
  - Required: valid_out, y_out, xfer_cnt_out and grant_out go to 0 immediately. After release, round-robin restarts at channel 0.
